// File: rtl/reg_view_vga.sv
// reg_view_vga: draws a per-frame snapshot of NUM_REGS registers as a hex
// label/value grid, highlighting values that changed at the last frame boundary.
// Two-stage pixel pipeline: stage 1 decodes geometry and captures the snapshot
// digit, stage 2 resolves the glyph and colour.
module reg_view_vga #(
    parameter int NUM_REGS      = 8,
    parameter int DATA_W        = 16,
    parameter int X_START       = 40,
    parameter int Y_START       = 40,
    parameter int BOX_HEIGHT    = 38,
    parameter int LABEL_W       = 64,
    parameter int TEXT_X_OFFSET = 10,
    parameter int TEXT_Y_OFFSET = 10,
    parameter int CHAR_W        = 5,
    parameter int CHAR_H        = 7,
    parameter int DIGIT_PITCH   = 8,
    parameter int HILITE_FRAMES = 30
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [9:0]                 draw_x,
    input  logic [8:0]                 draw_y,
    input  logic                       pix_valid,
    input  logic                       frame_start,
    input  logic [NUM_REGS*DATA_W-1:0] regs_flat,
    output logic [23:0]                VGA_COLOR,
    output logic                       plot,
    output logic                       out_valid,
    output logic [9:0]                 out_x,
    output logic [8:0]                 out_y
);

    localparam int HEX_DIGITS = (DATA_W + 3) / 4;
    localparam int PAD_W      = HEX_DIGITS * 4;
    localparam int VALUE_W    = 2 * TEXT_X_OFFSET + HEX_DIGITS * DIGIT_PITCH;
    localparam int X_END      = X_START + LABEL_W + VALUE_W;
    localparam int Y_END      = Y_START + NUM_REGS * BOX_HEIGHT;
    localparam int LBL_X0     = X_START + TEXT_X_OFFSET;
    localparam int VAL_X0     = X_START + LABEL_W + TEXT_X_OFFSET;
    localparam int SEG_MID    = CHAR_H / 2;

    localparam logic [8:0] C_HILITE = 9'h1F8;
    localparam logic [8:0] C_DATA   = 9'h1C0;
    localparam logic [8:0] C_LABEL  = 9'h038;
    localparam logic [8:0] C_LINE   = 9'h1FF;
    localparam logic [8:0] C_BACK   = 9'h000;

    typedef enum logic {UNPRIMED, RUN} ctrl_state_e;

    // Segment set for a hex digit, bit order {a,b,c,d,e,f,g}; b and d lowercase.
    function automatic logic [6:0] font7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0: s = 7'h7E;
            4'h1: s = 7'h30;
            4'h2: s = 7'h6D;
            4'h3: s = 7'h79;
            4'h4: s = 7'h33;
            4'h5: s = 7'h5B;
            4'h6: s = 7'h5F;
            4'h7: s = 7'h70;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h7B;
            4'hA: s = 7'h77;
            4'hB: s = 7'h1F;
            4'hC: s = 7'h4E;
            4'hD: s = 7'h3D;
            4'hE: s = 7'h4F;
            default: s = 7'h47;
        endcase
        return s;
    endfunction

    // True when glyph-local pixel (gx,gy) lies on a lit 1-pixel segment.
    function automatic logic seg_pixel(input logic [6:0] seg, input int gx, input int gy);
        logic mid_x;
        logic upper;
        logic lower;
        mid_x = (gx >= 1) && (gx <= CHAR_W - 2);
        upper = (gy >= 1) && (gy <= SEG_MID);
        lower = (gy > SEG_MID) && (gy <= CHAR_H - 1);
        return (seg[6] && mid_x && (gy == 0))
            || (seg[5] && (gx == CHAR_W - 1) && upper)
            || (seg[4] && (gx == CHAR_W - 1) && lower)
            || (seg[3] && mid_x && (gy == CHAR_H - 1))
            || (seg[2] && (gx == 0) && lower)
            || (seg[1] && (gx == 0) && upper)
            || (seg[0] && mid_x && (gy == SEG_MID));
    endfunction

    // 3:3:3 to 8:8:8 by bit replication.
    function automatic logic [23:0] expand(input logic [8:0] c);
        return {c[8:6], c[8:6], c[8:7], c[5:3], c[5:3], c[5:4], c[2:0], c[2:0], c[2:1]};
    endfunction

    ctrl_state_e                 state_q, state_d;
    logic [NUM_REGS*DATA_W-1:0]  snap_q;
    logic [7:0]                  hl_cnt_q [NUM_REGS];
    logic [7:0]                  hl_cnt_d [NUM_REGS];

    // Control state register: primed after the first frame boundary.
    always_ff @(posedge clock) begin
        if (reset) state_q <= UNPRIMED;
        else       state_q <= state_d;
    end

    // Next control state.
    always_comb begin
        state_d = state_q;
        if (state_q == UNPRIMED && frame_start) state_d = RUN;
    end

    // Highlight counters: reload on a change seen at a frame boundary, else count down.
    always_comb begin
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            hl_cnt_d[r] = hl_cnt_q[r];
            if (frame_start) begin
                if (state_q == RUN && regs_flat[r*DATA_W +: DATA_W] != snap_q[r*DATA_W +: DATA_W])
                    hl_cnt_d[r] = 8'(HILITE_FRAMES);
                else if (hl_cnt_q[r] != '0)
                    hl_cnt_d[r] = hl_cnt_q[r] - 8'd1;
            end
        end
    end

    // Snapshot and highlight state, updated only at the frame boundary.
    always_ff @(posedge clock) begin
        if (reset) begin
            snap_q   <= '0;
            hl_cnt_q <= '{default: '0};
        end else begin
            if (frame_start) snap_q <= regs_flat;
            hl_cnt_q <= hl_cnt_d;
        end
    end

    // Stage 1 decode signals.
    int                xi, yi, yrel, row, yin, gy, lx, vx, dig, dx;
    logic              in_grid, on_line, gy_ok, lab_hit, val_hit, hl;
    logic [DATA_W-1:0] word;
    logic [PAD_W-1:0]  padded;
    logic [3:0]        nib;

    // Geometry decode; the row's digit and highlight are read here so a pixel
    // coincident with frame_start sees the pre-update snapshot.
    always_comb begin
        xi   = int'(draw_x);
        yi   = int'(draw_y);
        yrel = yi - Y_START;
        row  = 0;
        for (int unsigned r = 1; r < NUM_REGS; r++)
            if (yrel >= int'(r) * BOX_HEIGHT) row = int'(r);
        yin = yrel - row * BOX_HEIGHT;

        in_grid = (xi >= X_START) && (xi < X_END) && (yi >= Y_START) && (yi < Y_END);
        on_line = (yi == Y_START) || (yin == BOX_HEIGHT - 1) || (xi == X_START)
               || (xi == X_START + LABEL_W - 1) || (xi == X_END - 1);

        gy    = yin - TEXT_Y_OFFSET;
        gy_ok = (gy >= 0) && (gy < CHAR_H);
        lx    = xi - LBL_X0;
        vx    = xi - VAL_X0;
        dig   = 0;
        for (int unsigned k = 1; k < HEX_DIGITS; k++)
            if (vx >= int'(k) * DIGIT_PITCH) dig = int'(k);
        dx = vx - dig * DIGIT_PITCH;

        lab_hit = gy_ok && (lx >= 0) && (lx < CHAR_W);
        val_hit = gy_ok && (vx >= 0) && (vx < HEX_DIGITS * DIGIT_PITCH) && (dx < CHAR_W);

        word = '0;
        hl   = 1'b0;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            if (int'(r) == row) begin
                word = snap_q[r*DATA_W +: DATA_W];
                hl   = (hl_cnt_q[r] != '0);
            end
        end
        padded = '0;
        padded[DATA_W-1:0] = word;
        nib = '0;
        for (int unsigned k = 0; k < HEX_DIGITS; k++)
            if (int'(k) == dig) nib = padded[(HEX_DIGITS-1-k)*4 +: 4];
    end

    logic       s1_valid_q, s1_in_grid_q, s1_line_q, s1_lab_q, s1_val_q, s1_hl_q;
    logic [9:0] s1_x_q;
    logic [8:0] s1_y_q;
    logic [3:0] s1_row_q, s1_nib_q;
    logic [5:0] s1_gx_q, s1_gy_q;

    // Stage 1 register: coordinates, row, selected digit and grid decode.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid_q   <= 1'b0;
            s1_in_grid_q <= 1'b0;
            s1_line_q    <= 1'b0;
            s1_lab_q     <= 1'b0;
            s1_val_q     <= 1'b0;
            s1_hl_q      <= 1'b0;
            s1_x_q       <= '0;
            s1_y_q       <= '0;
            s1_row_q     <= '0;
            s1_nib_q     <= '0;
            s1_gx_q      <= '0;
            s1_gy_q      <= '0;
        end else begin
            s1_valid_q   <= pix_valid;
            s1_in_grid_q <= in_grid;
            s1_line_q    <= on_line;
            s1_lab_q     <= lab_hit;
            s1_val_q     <= val_hit;
            s1_hl_q      <= hl;
            s1_x_q       <= draw_x;
            s1_y_q       <= draw_y;
            s1_row_q     <= 4'(row);
            s1_nib_q     <= nib;
            s1_gx_q      <= lab_hit ? 6'(lx) : 6'(dx);
            s1_gy_q      <= 6'(gy);
        end
    end

    logic [3:0] glyph_char;
    logic       glyph_px;
    logic [8:0] color9;

    // Glyph lookup and colour priority: value, label, grid line, background.
    always_comb begin
        glyph_char = s1_val_q ? s1_nib_q : s1_row_q;
        glyph_px   = seg_pixel(font7(glyph_char), int'(s1_gx_q), int'(s1_gy_q));
        if (!s1_in_grid_q)             color9 = C_BACK;
        else if (s1_val_q && glyph_px) color9 = s1_hl_q ? C_HILITE : C_DATA;
        else if (s1_lab_q && glyph_px) color9 = C_LABEL;
        else if (s1_line_q)            color9 = C_LINE;
        else                           color9 = C_BACK;
    end

    logic [23:0] color_q;
    logic        plot_q, valid_q;
    logic [9:0]  x_q;
    logic [8:0]  y_q;

    // Stage 2 register: colour and coordinates hold while no pixel is valid.
    always_ff @(posedge clock) begin
        if (reset) begin
            color_q <= '0;
            plot_q  <= 1'b0;
            valid_q <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            valid_q <= s1_valid_q;
            plot_q  <= s1_valid_q && s1_in_grid_q;
            if (s1_valid_q) begin
                color_q <= expand(color9);
                x_q     <= s1_x_q;
                y_q     <= s1_y_q;
            end
        end
    end

    assign VGA_COLOR = color_q;
    assign plot      = plot_q;
    assign out_valid = valid_q;
    assign out_x     = x_q;
    assign out_y     = y_q;

endmodule

// File: doc/reg_view_vga.md
# reg_view_vga

Parametrised, clocked register-file viewer for the VGA frontend. It draws NUM_REGS registers of DATA_W bits as multi-digit hex values in a label/value grid. Register contents are snapshotted once per frame so a frame never tears. Any register whose value changed since the previous frame is highlighted for HILITE_FRAMES frames. It sits between the CPU register file and the VGA adapter's pixel-write port, replacing the fixed 8×4-bit combinational viewer, and drives a registered pixel stream.

## Interface
- NUM_REGS, 8: registers displayed, 1..16; label digit is the index in hex.
- DATA_W, 16: bits per register, 4..32; HEX_DIGITS = ceil(DATA_W/4), MSB digit leftmost, upper pad bits zero.
- X_START, 40 / Y_START, 40: grid top-left pixel.
- BOX_HEIGHT, 38: row pitch in pixels.
- LABEL_W, 64: label column width.
- TEXT_X_OFFSET, 10 / TEXT_Y_OFFSET, 10: glyph offset inside a box.
- CHAR_W, 5 / CHAR_H, 7 / DIGIT_PITCH, 8: 7-segment glyph size and digit spacing.
- HILITE_FRAMES, 30: frames a changed value stays highlighted, 1..255.
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- draw_x  in  10  pixel column.
- draw_y  in  9  pixel row.
- pix_valid  in  1  draw_x/draw_y are valid this cycle.
- frame_start  in  1  one-cycle pulse marking the frame boundary.
- regs_flat  in  NUM_REGS*DATA_W  register contents; Ri = regs_flat[i*DATA_W +: DATA_W].
- VGA_COLOR  out  24  8:8:8 colour, expanded from internal 3:3:3 by bit replication {c,c,c[msb]}.
- plot  out  1  pixel lies inside the grid and out_valid=1.
- out_valid  out  1  stage-2 pixel valid.
- out_x  out  10 / out_y  out  9  coordinates matching VGA_COLOR.

## Operation
- Geometry:
  - VALUE_W = 2*TEXT_X_OFFSET + HEX_DIGITS*DIGIT_PITCH.
  - Grid spans x in [X_START, X_START+LABEL_W+VALUE_W) and y in [Y_START, Y_START+NUM_REGS*BOX_HEIGHT).
  - Row = (y-Y_START)/BOX_HEIGHT.
- Grid lines (LINE 9'h1FF):
  - Horizontal: y==Y_START, or (y-Y_START)%BOX_HEIGHT==BOX_HEIGHT-1.
  - Vertical: x==X_START, x==X_START+LABEL_W-1, or x==X_START+LABEL_W+VALUE_W-1.
- Glyph origins:
  - Label digit at (X_START+TEXT_X_OFFSET, Y_START+row*BOX_HEIGHT+TEXT_Y_OFFSET).
  - Value digit k (k=0 is MSB) at x = X_START+LABEL_W+TEXT_X_OFFSET+k*DIGIT_PITCH, same y.
- Glyph shape: 7-segment hex font with lowercase b/d, 1-pixel segments. A/D span x 1..3; B/C/E/F span y 1..3 and 4..6; G at y==3.
- Colour priority, highest first:
  1. Value glyph: HILITE 9'h1F8 (yellow) if that row's hl_cnt≠0, else DATA 9'h1C0.
  2. Label glyph: LABEL 9'h038.
  3. Grid line.
  4. BACK 9'h000.
- Snapshot, on each frame_start:
  - snap ← regs_flat; prev ← snap.
  - Per row: if primed && new≠snap_old, hl_cnt ← HILITE_FRAMES; else if hl_cnt≠0, hl_cnt ← hl_cnt−1.
  - primed ← 1.
  - The first frame_start after reset never highlights.
- Rendering always uses snap, never live regs_flat.
- Control state: UNPRIMED → (frame_start) → RUN. Reset returns to UNPRIMED.

## Timing
- Two-stage pipeline:
  - Stage 1 registers the coordinates, row, digit index and in-grid decode.
  - Stage 2 registers VGA_COLOR, plot, out_valid, out_x, out_y.
  - Latency is exactly 2 cycles; throughput is 1 pixel/clock; there is no backpressure.
- A pixel presented in the same cycle as frame_start uses the pre-update snap and hl_cnt values.
- out_valid follows pix_valid delayed by 2 cycles. When out_valid=0, plot=0 and VGA_COLOR holds its last value.
- Reset values:
  - VGA_COLOR=0, plot=0, out_valid=0, out_x=0, out_y=0.
  - snap=0, all hl_cnt=0, primed=0, pipeline valids=0.
- Reset asserted mid-stream flushes both pipeline stages on the next edge.
- Coordinates outside the grid force plot=0 and output BACK.

## Test plan
- Reset, then pix_valid with (40,40) → two cycles later out_valid=1, plot=1, VGA_COLOR=24'hFFFFFF, out_x=40, out_y=40.
- DATA_W=16, R2=16'hA5C3, one frame_start, sweep row 2 → value digits render "A","5","C","3" MSB-left in red 24'hFFFFFF-free DATA (24'hFF0000 expanded); label reads "2" in 24'h00FF00.
- Snapshot frame, then change R1 from 0 to 7 mid-frame → row 1 still shows 0 until the next frame_start. After it, row 1 renders 7 in 24'hFFFF00 for 30 frames, and in DATA colour at frame 31.
- First frame_start after reset with all regs nonzero → no highlight (all hl_cnt=0).
- R4 changes again during its highlight window → hl_cnt reloads to HILITE_FRAMES, so the highlight is extended.
- pixel (39,40) or (40,40+8*38) → plot=0. pix_valid toggling 1,0,1 → out_valid toggles 1,0,1 two cycles later. Reset asserted during the stream → out_valid=0 on the next cycle.
